// File: rtl/dram_cache_pkg.sv
// Shared DRAM-cache types: issuer FSM states, tag FIFO entry layout and
// AXI burst constants used by the tag issuer and the tag comparator.
package dram_cache_pkg;

    localparam int TAG_ADDR_W   = 32;
    localparam int TAG_ID_W     = 4;
    localparam int TAG_INDEX_W  = 10;
    localparam int TAG_OFFSET_W = 6;
    localparam int TAG_DATA_W   = 64;

    localparam logic [1:0] AXI_BURST_INCR = 2'b01;
    localparam int         TAG_BURST_LEN  = 8;

    typedef enum logic {
        S_IDLE,
        S_AR
    } issuer_state_e;

    typedef struct packed {
        logic                  write;
        logic [TAG_ID_W-1:0]   id;
        logic [TAG_ADDR_W-1:0] addr;
    } tag_fifo_entry_t;

endpackage

// File: rtl/outstanding_credit.sv
// Outstanding AR burst counter: +1 per AR handshake, -1 per rlast beat.
// Ports: clk, rst, inc, dec in; full out (count == MAX_OUTSTANDING).
module outstanding_credit #(
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    output logic full
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [CNT_W-1:0] cnt;

    // Simultaneous inc and dec cancel out; both ends saturate.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc && !dec && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
        end else if (dec && !inc && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign full = (cnt == CNT_MAX);

    // An rlast with no burst in flight means the R channel is broken.
    a_no_underflow: assert property (
        @(posedge clk) disable iff (rst) !(dec && !inc && cnt == '0)
    );

endmodule

// File: rtl/tag_lookup_issuer.sv
// Issues one AXI AR line fetch per cache request and pushes the matching
// tag FIFO entry {write, id, addr} in the AR handshake cycle, throttling
// acceptance on FIFO almost-full and on MAX_OUTSTANDING bursts in flight.
// Ports: clk/rst; req_* front-end request; ar* AXI AR master; rvalid/
// rready/rlast snooped R; tag_fifo_* FIFO push; stat_* lookup counters.
// Optional: TAG_ISSUE_STATS_EN enables the read/write lookup counters.
module tag_lookup_issuer
    import dram_cache_pkg::*;
#(
    parameter int ADDR_WIDTH      = TAG_ADDR_W,
    parameter int ID_WIDTH        = TAG_ID_W,
    parameter int INDEX_WIDTH     = TAG_INDEX_W,
    parameter int OFFSET_WIDTH    = TAG_OFFSET_W,
    parameter int DATA_WIDTH      = TAG_DATA_W,
    parameter int BURST_LEN       = TAG_BURST_LEN,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid_i,
    output logic                          req_ready_o,
    input  logic [ADDR_WIDTH-1:0]         req_addr_i,
    input  logic [ID_WIDTH-1:0]           req_id_i,
    input  logic                          req_write_i,
    output logic [ID_WIDTH-1:0]           arid_o,
    output logic [ADDR_WIDTH-1:0]         araddr_o,
    output logic [7:0]                    arlen_o,
    output logic [2:0]                    arsize_o,
    output logic [1:0]                    arburst_o,
    output logic                          arvalid_o,
    input  logic                          arready_i,
    input  logic                          rvalid_i,
    input  logic                          rready_i,
    input  logic                          rlast_i,
    input  logic                          tag_fifo_afull_i,
    output logic                          tag_fifo_wren_o,
    output logic [ADDR_WIDTH+ID_WIDTH:0]  tag_fifo_wdata_o,
    output logic [31:0]                   stat_rd_cnt_o,
    output logic [31:0]                   stat_wr_cnt_o
);

    localparam int ENTRY_W = ADDR_WIDTH + ID_WIDTH + 1;
    localparam int SET_LSB = OFFSET_WIDTH;
    localparam int TAG_LSB = OFFSET_WIDTH + INDEX_WIDTH;

    issuer_state_e      state;
    logic [ENTRY_W-1:0] entry;
    logic               ar_hs;
    logic               r_done;
    logic               credit_full;

    assign ar_hs  = arvalid_o && arready_i;
    assign r_done = rvalid_i && rready_i && rlast_i;

    // rst term keeps ready low while reset is held.
    assign req_ready_o = !rst && state == S_IDLE
                      && !tag_fifo_afull_i && !credit_full;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            arvalid_o <= 1'b0;
            entry     <= '0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (req_valid_i && req_ready_o) begin
                        entry     <= {req_write_i, req_id_i, req_addr_i};
                        arvalid_o <= 1'b1;
                        state     <= S_AR;
                    end
                end
                S_AR: begin
                    if (arready_i) begin
                        arvalid_o <= 1'b0;
                        state     <= S_IDLE;
                    end
                end
                default: begin
                    arvalid_o <= 1'b0;
                    state     <= S_IDLE;
                end
            endcase
        end
    end

    // Line-aligned fetch: tag bits and set index kept, offset cleared.
    assign araddr_o = {entry[ADDR_WIDTH-1:TAG_LSB],
                       entry[TAG_LSB-1:SET_LSB],
                       {OFFSET_WIDTH{1'b0}}};
    assign arid_o    = entry[ADDR_WIDTH +: ID_WIDTH];
    assign arlen_o   = 8'(BURST_LEN - 1);
    assign arsize_o  = 3'($clog2(DATA_WIDTH / 8));
    assign arburst_o = AXI_BURST_INCR;

    // Push in the handshake cycle so FIFO order tracks R-burst order.
    assign tag_fifo_wren_o  = ar_hs;
    assign tag_fifo_wdata_o = entry;

    outstanding_credit #(
        .MAX_OUTSTANDING(MAX_OUTSTANDING)
    ) u_credit (
        .clk  (clk),
        .rst  (rst),
        .inc  (ar_hs),
        .dec  (r_done),
        .full (credit_full)
    );

`ifdef TAG_ISSUE_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_rd_cnt_o <= '0;
            stat_wr_cnt_o <= '0;
        end else if (ar_hs) begin
            if (entry[ENTRY_W-1]) stat_wr_cnt_o <= stat_wr_cnt_o + 1'b1;
            else                  stat_rd_cnt_o <= stat_rd_cnt_o + 1'b1;
        end
    end
`else
    assign stat_rd_cnt_o = '0;
    assign stat_wr_cnt_o = '0;
`endif

endmodule
